uart_rx: RTL
============

Name: uart_rx

Overview:
- 8N1 UART receiver; the downstream consumer of the tx serial line (txd) in the UART design.
- Samples the asynchronous serial input at 16x the baud rate and checks the start and stop bits.
- Presents each received byte with a one-cycle valid strobe and flags framing errors.
- Used for tx loopback testing on the board and as the receive half of the link.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s.
- OVERSAMPLE, 16, sample ticks per bit. Fixed at 16; other values are unsupported.
- DIV, CLK_FREQ/(BAUD*OVERSAMPLE) with truncation (651 at defaults), clocks per sample tick. Derived, not overridden.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- rxd  in  1  serial input; idle high; asynchronous to clk.
- data  out  8  last correctly framed byte; bit 0 is the first bit received.
- data_valid  out  1  one-cycle pulse; data is updated in the same cycle.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: data=8'h00, data_valid=0, frame_err=0, busy=0, state=IDLE.
- Reset also clears all counters and sets both synchronizer flops to 1. Reset mid-frame abandons the frame with no strobe.
- Synchronizer: rxd passes through 2 flops to give rxs. All decisions use rxs, which adds 2 cycles of input latency.
- Tick generator: free-running counter 0..DIV-1. tick=1 for one cycle when count==DIV-1, then the count wraps to 0. It runs in every state.
- The FSM acts only in cycles where tick=1. os_cnt is 4 bits; bit_idx is 3 bits.
- IDLE: if rxs==0, go to START with os_cnt=0.
- START: increment os_cnt on each tick. At os_cnt==7 (mid start bit):
  - rxs==0: go to DATA with os_cnt=0, bit_idx=0.
  - rxs==1: glitch; return to IDLE with no strobe.
- DATA: increment os_cnt on each tick. At os_cnt==15, shift rxs into the MSB of shreg (right shift, so bits end up LSB-first) and reset os_cnt to 0.
  - If bit_idx==7, go to STOP; otherwise increment bit_idx.
- STOP: increment os_cnt on each tick. At os_cnt==15:
  - rxs==1: data<=shreg and data_valid=1 in that same cycle; go to IDLE.
  - rxs==0: frame_err=1, data is held unchanged; go to WAIT_HIGH.
- WAIT_HIGH: go to IDLE on the first tick with rxs==1. A break (continuous low) therefore never retriggers reception.
- Strobes are registered and last exactly one clk cycle. data_valid and frame_err are never high together.
- Latency: the strobe comes 1 cycle after the stop-sample tick. That is about 9.5 bit times after the falling start edge, plus 2 synchronizer cycles, plus up to 1 tick of edge-detect quantization.
- Back-to-back frames: a start edge arriving right after the stop sample is detected. The first tick in IDLE may already be inside the next start bit; this is tolerated, since the mid-bit sample point shifts by at most 1 tick.
- Baud tolerance: combined clock error between tx and rx up to ±3%.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, WAIT_HIGH};
  - OVERSAMPLE=16, DATA_BITS=8, MID_SAMPLE=7;
  - default CLK_FREQ and BAUD.
- One sub-module: uart_baud_tick (parameter DIV; ports clk, reset, tick). It is also reusable by tx.

Test Plan:
All scenarios use CLK_FREQ=1_600_000 and BAUD=10_000, so DIV=10 and 1 bit = 160 clk.
- Send 0xA5 (8N1, LSB first) -> one data_valid pulse of exactly 1 cycle, data==8'hA5, frame_err never high, busy low afterwards.
- Send 0x00 then 0xFF back-to-back with no idle gap -> two data_valid pulses about 1600 clk apart, with data 8'h00 then 8'hFF.
- Drive rxd low for 30 clk, then high -> no strobe, state back in IDLE within 80 clk, data unchanged.
- Send 0x3C with the stop bit driven 0, holding rxd low for a further 400 clk -> exactly one frame_err pulse, data keeps its prior value. Then send 0x5A -> data==8'h5A.
- Assert reset after the 4th data bit of 0x81 -> all outputs at reset values immediately, with no strobe. Then send 0x81 -> data==8'h81.
- Send 0x55 at a baud rate 3% fast, then 3% slow -> data==8'h55 both times, no frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, framing constants and
// default clock/baud settings used by both halves of the link.
package uart_pkg;

  localparam int OVERSAMPLE       = 16;
  localparam int DATA_BITS        = 8;
  localparam int MID_SAMPLE       = 7;
  localparam int DEFAULT_CLK_FREQ = 100_000_000;
  localparam int DEFAULT_BAUD     = 9600;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  // Clocks per oversample tick, truncating.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks; shared
// between the receiver (16x oversampling) and the transmitter.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling, framing-error
// detection and break handling (a held-low line never retriggers reception).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = uart_pkg::DEFAULT_CLK_FREQ,
  parameter int BAUD       = uart_pkg::DEFAULT_BAUD,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;

  localparam logic [3:0] OS_MID  = 4'(MID_SAMPLE);
  localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  logic       tick;
  logic [1:0] sync_reg;
  logic       rxs;

  state_t     state_reg,      state_next;
  logic [3:0] os_cnt_reg,     os_cnt_next;
  logic [2:0] bit_idx_reg,    bit_idx_next;
  logic [7:0] shreg_reg,      shreg_next;
  logic [7:0] data_reg,       data_next;
  logic       data_valid_reg, data_valid_next;
  logic       frame_err_reg,  frame_err_next;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rxd};
    end
  end

  assign rxs = sync_reg[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      os_cnt_reg     <= '0;
      bit_idx_reg    <= '0;
      shreg_reg      <= '0;
      data_reg       <= '0;
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      os_cnt_reg     <= os_cnt_next;
      bit_idx_reg    <= bit_idx_next;
      shreg_reg      <= shreg_next;
      data_reg       <= data_next;
      data_valid_reg <= data_valid_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    os_cnt_next     = os_cnt_reg;
    bit_idx_next    = bit_idx_reg;
    shreg_next      = shreg_reg;
    data_next       = data_reg;
    data_valid_next = 1'b0;
    frame_err_next  = 1'b0;

    if (tick) begin
      case (state_reg)
        IDLE: begin
          if (!rxs) begin
            state_next  = START;
            os_cnt_next = '0;
          end
        end

        // Re-check the line at the middle of the start bit to reject glitches.
        START: begin
          os_cnt_next = os_cnt_reg + 4'd1;
          if (os_cnt_reg == OS_MID) begin
            if (!rxs) begin
              state_next   = DATA;
              os_cnt_next  = '0;
              bit_idx_next = '0;
            end else begin
              state_next = IDLE;
            end
          end
        end

        DATA: begin
          os_cnt_next = os_cnt_reg + 4'd1;
          if (os_cnt_reg == OS_LAST) begin
            shreg_next  = {rxs, shreg_reg[7:1]};
            os_cnt_next = '0;
            if (bit_idx_reg == BIT_LAST) begin
              state_next = STOP;
            end else begin
              bit_idx_next = bit_idx_reg + 3'd1;
            end
          end
        end

        STOP: begin
          os_cnt_next = os_cnt_reg + 4'd1;
          if (os_cnt_reg == OS_LAST) begin
            if (rxs) begin
              data_next       = shreg_reg;
              data_valid_next = 1'b1;
              state_next      = IDLE;
            end else begin
              frame_err_next = 1'b1;
              state_next     = WAIT_HIGH;
            end
          end
        end

        WAIT_HIGH: begin
          if (rxs) begin
            state_next = IDLE;
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign data       = data_reg;
  assign data_valid = data_valid_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = (state_reg != IDLE);

endmodule
